// File: rtl/nvram_arbiter_if.sv
// Bus bundle between the NVRAM arbiter and its neighbours: game CPU, hps_io ioctl and CMOS RAM.
// master = environment side (CPU, HPS, RAM); slave = the arbiter.
interface nvram_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) ();
    logic              cpu_cs;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_pause;
    logic              cpu_halted;

    logic              ioctl_download;
    logic              ioctl_upload;
    logic [15:0]       ioctl_index;
    logic [24:0]       ioctl_addr;
    logic              ioctl_wr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_rd;
    logic [7:0]        ioctl_din;

    logic              clear_req;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    logic              busy;

    modport master (
        output cpu_cs, cpu_we, cpu_addr, cpu_din, cpu_halted,
        output ioctl_download, ioctl_upload, ioctl_index, ioctl_addr, ioctl_wr, ioctl_dout,
        output ioctl_rd, clear_req, ram_dout,
        input  cpu_dout, cpu_pause, ioctl_din, ram_addr, ram_din, ram_we, busy
    );

    modport slave (
        input  cpu_cs, cpu_we, cpu_addr, cpu_din, cpu_halted,
        input  ioctl_download, ioctl_upload, ioctl_index, ioctl_addr, ioctl_wr, ioctl_dout,
        input  ioctl_rd, clear_req, ram_dout,
        output cpu_dout, cpu_pause, ioctl_din, ram_addr, ram_din, ram_we, busy
    );
endinterface

// File: rtl/nvram_arbiter.sv
// Single-port CMOS/high-score RAM arbiter: CPU owns the port in idle; HPS load/save and the
// high-score clear sequencer take it over after halting the CPU via a pause handshake.
module nvram_arbiter #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 8,
    parameter logic [15:0] NV_INDEX  = 16'd4,
    parameter logic [7:0]  CLEAR_VAL = 8'h00
) (
    input logic            clk_sys,
    input logic            reset,
    nvram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StPauseWait,
        StLoad,
        StSave,
        StClear,
        StRelease
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clear_pend_q, clear_pend_d;
    logic              rearm_q, rearm_d;
    logic              clear_req_q;
    logic              cpu_rd_q;
    logic [DATA_W-1:0] cpu_hold_q;
    logic              sv_rd_q;
    logic              sv_oob_q;
    logic [7:0]        sv_hold_q;

    logic              hps_ld, hps_sv, clear_edge, io_in_range;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we, cpu_pause, busy;
    logic [7:0]        ioctl_din;

    assign hps_ld      = bus.ioctl_download && (bus.ioctl_index == NV_INDEX);
    assign hps_sv      = bus.ioctl_upload && (bus.ioctl_index == NV_INDEX);
    assign clear_edge  = bus.clear_req && !clear_req_q;
    assign io_in_range = (bus.ioctl_addr >> ADDR_W) == 25'd0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clear_pend_d = clear_pend_q | clear_edge;
        rearm_d      = rearm_q;
        ram_addr     = bus.cpu_addr;
        ram_din      = bus.cpu_din;
        ram_we       = 1'b0;
        cpu_pause    = 1'b0;
        busy         = 1'b1;
        unique case (state_q)
            StIdle: begin
                busy   = 1'b0;
                ram_we = bus.cpu_cs && bus.cpu_we;
                if (hps_ld || hps_sv || clear_pend_q) state_d = StPauseWait;
            end
            StPauseWait: begin
                cpu_pause = 1'b1;
                if (bus.cpu_halted) begin
                    if (hps_ld)            state_d = StLoad;
                    else if (hps_sv)       state_d = StSave;
                    else if (clear_pend_q) state_d = StClear;
                    else                   state_d = StRelease;
                end else if (!(hps_ld || hps_sv || clear_pend_q)) begin
                    state_d = StRelease;
                end
            end
            StLoad: begin
                cpu_pause = 1'b1;
                ram_addr  = bus.ioctl_addr[ADDR_W-1:0];
                ram_din   = DATA_W'(bus.ioctl_dout);
                ram_we    = hps_ld && bus.ioctl_wr && io_in_range;
                if (!hps_ld) state_d = (clear_pend_q || clear_edge) ? StClear : StRelease;
            end
            StSave: begin
                cpu_pause = 1'b1;
                ram_addr  = bus.ioctl_addr[ADDR_W-1:0];
                if (!hps_sv) state_d = (clear_pend_q || clear_edge) ? StClear : StRelease;
            end
            StClear: begin
                cpu_pause = 1'b1;
                ram_addr  = cnt_q;
                ram_din   = DATA_W'(CLEAR_VAL);
                ram_we    = 1'b1;
                // A fresh edge mid-clear must survive the end-of-run flag clear.
                if (clear_edge) rearm_d = 1'b1;
                if (cnt_q == '1) begin
                    cnt_d        = '0;
                    clear_pend_d = rearm_q | clear_edge;
                    rearm_d      = 1'b0;
                    state_d      = StRelease;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            clear_pend_q <= 1'b0;
            rearm_q      <= 1'b0;
            clear_req_q  <= bus.clear_req;
            cpu_rd_q     <= 1'b0;
            cpu_hold_q   <= '0;
            sv_rd_q      <= 1'b0;
            sv_oob_q     <= 1'b0;
            sv_hold_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clear_pend_q <= clear_pend_d;
            rearm_q      <= rearm_d;
            clear_req_q  <= bus.clear_req;
            cpu_rd_q     <= (state_q == StIdle) && bus.cpu_cs && !bus.cpu_we;
            if (cpu_rd_q) cpu_hold_q <= bus.ram_dout;
            sv_rd_q      <= (state_q == StSave) && bus.ioctl_rd;
            sv_oob_q     <= !io_in_range;
            if (sv_rd_q) sv_hold_q <= ioctl_din;
        end
    end

    // Read data comes straight from the RAM's output register in the cycle after the request,
    // and is held afterwards.
    assign ioctl_din = sv_rd_q ? (sv_oob_q ? 8'hFF : 8'(bus.ram_dout)) : sv_hold_q;

    assign bus.cpu_dout  = cpu_rd_q ? bus.ram_dout : cpu_hold_q;
    assign bus.ioctl_din = ioctl_din;
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_din   = ram_din;
    assign bus.ram_we    = ram_we;
    assign bus.cpu_pause = cpu_pause;
    assign bus.busy      = busy;

endmodule
